// File: rtl/file_stream_writer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : file_stream_writer_if
//  Purpose  : Word-in / byte-out bus bundle for file_stream_writer.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
interface file_stream_writer_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] ramBase;
   logic [CNT_W-1:0]  word_count;
   logic              msb_first;
   logic [DATA_W-1:0] captured_data;
   logic              in_valid;
   logic              in_ready;
   logic              ram_busy;
   logic              write;
   logic [ADDR_W-1:0] ramAddress;
   logic [7:0]        ramData;
   logic              busy;
   logic              done;

   modport slave (
      input  start, abort, ramBase, word_count, msb_first,
             captured_data, in_valid, ram_busy,
      output in_ready, write, ramAddress, ramData, busy, done
   );

   modport master (
      output start, abort, ramBase, word_count, msb_first,
             captured_data, in_valid, ram_busy,
      input  in_ready, write, ramAddress, ramData, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/file_stream_writer.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module   : file_stream_writer
//  Purpose  : Splits a burst of DATA_W-bit words into bytes written to RAM.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module file_stream_writer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
) (
   input  wire logic          clk,
   input  wire logic          RST,
   file_stream_writer_if.slave bus
);
   localparam int c_BYTES = DATA_W / 8;
   localparam int c_IDX_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_WORD = 2'd1,
      SEND      = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t             r_state;
   logic [ADDR_W-1:0]  r_addr;
   logic [CNT_W-1:0]   r_words_left;
   logic [c_IDX_W-1:0] r_byte_idx;
   logic [DATA_W-1:0]  r_shift;
   logic               r_msb;

   logic [DATA_W-1:0]  w_shift_next;
   logic               w_last_byte;

   assign w_shift_next = r_msb ? (r_shift << 8) : (r_shift >> 8);
   assign w_last_byte  = (r_byte_idx == c_IDX_W'(c_BYTES - 1));

   // Outputs decode straight from state so an async reset clears them at once.
   assign bus.in_ready   = (r_state == WAIT_WORD);
   assign bus.write      = (r_state == SEND);
   assign bus.busy       = (r_state != IDLE);
   assign bus.done       = (r_state == DONE);
   assign bus.ramAddress = r_addr;
   assign bus.ramData    = r_msb ? r_shift[DATA_W-1 -: 8] : r_shift[7:0];

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_words_left <= '0;
         r_byte_idx   <= '0;
         r_shift      <= '0;
         r_msb        <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_addr       <= bus.ramBase;
                  r_words_left <= bus.word_count;
                  r_msb        <= bus.msb_first;
                  r_state      <= (bus.word_count == '0) ? DONE : WAIT_WORD;
               end
            end
            WAIT_WORD: begin
               if (bus.abort) begin
                  r_state <= IDLE;
               end else if (bus.in_valid) begin
                  r_shift    <= bus.captured_data;
                  r_byte_idx <= '0;
                  r_state    <= SEND;
               end
            end
            SEND: begin
               if (bus.abort) begin
                  r_state <= IDLE;
               end else if (!bus.ram_busy) begin
                  r_shift    <= w_shift_next;
                  r_addr     <= r_addr + ADDR_W'(1);
                  r_byte_idx <= r_byte_idx + c_IDX_W'(1);
                  if (w_last_byte) begin
                     r_words_left <= r_words_left - CNT_W'(1);
                     r_state      <= (r_words_left == CNT_W'(1)) ? DONE : WAIT_WORD;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire
